alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Pipeline stage directly downstream of the 16-bit ALU. Captures Z and the ALU flags
//   {Sign,Zero,Carry,Parity,Overflow} through a valid/ready handshake, using a 2-entry skid buffer.
//  Retires results to the writeback consumer.
//  Maintains an architectural status register, a sticky overflow bit and an overflow event counter.
//  Evaluates a branch condition code against the status register.
// PARAMETERS
//  WIDTH    16  data width of Z
//  CNT_W    8   width of the saturating overflow event counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      ALU result valid
//  in_ready   out  1      stage can accept; registered output (no comb path from out_ready)
//  in_z       in   WIDTH  ALU result Z
//  in_flags   in   5      {Sign,Zero,Carry,Parity,Overflow}, bit4..bit0
//  out_valid  out  1      retired result valid
//  out_ready  in   1      writeback consumer ready
//  out_z      out  WIDTH  head-of-buffer result
//  out_flags  out  5      head-of-buffer flags
//  stat       out  5      status register; same bit order as in_flags
//  cond       in   3      condition select (see BEHAVIOUR)
//  cond_true  out  1      combinational evaluation of cond against stat
//  ovf_sticky out  1      set by any retired Overflow=1; cleared by clr_sticky
//  ovf_count  out  CNT_W  count of retired Overflow=1 results; saturates at all-ones
//  clr_sticky in   1      clears ovf_sticky, ovf_count and par_err (when present)
//  par_err    out  1      present only with PARITY_CHECK_EN
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, out_z=0, out_flags=0, stat=0.
//   Reset also sets ovf_sticky=0, ovf_count=0 and par_err=0, and empties the buffer.
//   Reset mid-transfer drops all buffered entries.
//  Accept: in_valid&in_ready at a posedge writes the entry.
//  Retire: out_valid&out_ready at a posedge pops the head.
//  Ordering and latency:
//   - Entries retire strictly in FIFO order.
//   - Latency is 1 cycle: an entry accepted at edge N is visible on out_* after edge N.
//  Occupancy 0..2. in_ready=1 iff occupancy after the current edge is <2.
//   An accept and a retire in the same cycle at occupancy 2 is impossible, because in_ready=0.
//  Simultaneous accept and retire at occupancy 1: the new entry becomes the head; occupancy stays 1.
//  out_valid is 1 iff occupancy>0. out_z/out_flags hold steady while out_valid=1 and out_ready=0.
//  Retire side effects (same edge as the pop):
//   - stat <= retired flags.
//   - If the retired Overflow=1: ovf_sticky <= 1 and ovf_count <= ovf_count+1, saturating.
//  clr_sticky coinciding with a retire of an Overflow=1 entry: clear wins.
//   ovf_sticky=0 and ovf_count=0 after the edge.
//  stat is never cleared except by rst.
//  cond: 0 always, 1 Z, 2 !Z, 3 S, 4 C, 5 V, 6 P, 7 never. It is evaluated on the registered stat.
//  Parity convention: P=1 iff Z has an even number of ones.
// CONFIGURATION
//  PARITY_CHECK_EN defined:
//   - On each retire, recompute P'=~^out_z.
//   - If P' != out_flags[1], par_err <= 1 (sticky, cleared by clr_sticky or rst).
//  PARITY_CHECK_EN undefined: par_err is tied to 0 and no checker logic is present.
// TESTING
//  1. rst=1 for 2 cycles -> in_ready=1, out_valid=0, stat=0, ovf_count=0.
//  2. Accept Z=0x0FFF, flags=5'b00111 (8fff+8000) with out_ready=1.
//     -> Next cycle out_z=0x0FFF; after retire stat=00111, ovf_sticky=1, ovf_count=1, cond=5 gives 1.
//  3. out_ready=0; push 0x0000 (flags 01110) then 0xFFFF (flags 10010).
//     -> in_ready=0 after 2 accepts, out_z stays 0x0000.
//     Set out_ready=1: retires 0x0000 then 0xFFFF in order; final stat=10010; cond=3 gives 1, cond=1 gives 0.
//  4. Occupancy 1 with in_valid=1 and out_ready=1 held for 10 cycles.
//     -> One retire per cycle, in_ready stays 1, no loss or duplication (checked by scoreboard).
//  5. Retire 300 entries with Overflow=1 -> ovf_count=0xFF (saturated).
//     Then pulse clr_sticky -> ovf_count=0, ovf_sticky=0.
//  6. With PARITY_CHECK_EN, retire Z=0x0001 with P=1 -> par_err=1.
//     Without PARITY_CHECK_EN, par_err stays 0.

Source files
------------

// File: rtl/alu_result_stage.sv
// Result stage behind the 16-bit ALU: 2-entry skid buffer, status register, overflow tracking, branch condition.
// Optional parity recheck of retired results is enabled by defining PARITY_CHECK_EN.
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_z,
  input  logic [4:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic [4:0]       out_flags,
  output logic [4:0]       stat,
  input  logic [2:0]       cond,
  output logic             cond_true,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_sticky,
  output logic             par_err
);

  localparam int S_BIT = 4;
  localparam int Z_BIT = 3;
  localparam int C_BIT = 2;
  localparam int P_BIT = 1;
  localparam int V_BIT = 0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // p0 is the head of the buffer, p1 the entry behind it; vld_p1 implies vld_p0.
  logic             r_vld_p0, r_vld_p1;
  logic [WIDTH-1:0] r_z_p0, r_z_p1;
  logic [4:0]       r_f_p0, r_f_p1;
  logic             r_in_ready;
  logic [4:0]       r_stat;
  logic             r_ovf_sticky;
  logic [CNT_W-1:0] r_ovf_count;

  logic             w_push, w_pop;
  logic             w_vld_p0_nxt, w_vld_p1_nxt;
  logic             w_ld_p0_in, w_ld_p0_p1, w_ld_p1_in;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_vld_p0 & out_ready;

  always_comb begin
    w_vld_p0_nxt = r_vld_p0;
    w_vld_p1_nxt = r_vld_p1;
    w_ld_p0_in   = 1'b0;
    w_ld_p0_p1   = 1'b0;
    w_ld_p1_in   = 1'b0;
    if (w_pop && r_vld_p1) begin
      // in_ready is low when full, so no push can coincide with this shift
      w_ld_p0_p1   = 1'b1;
      w_vld_p1_nxt = 1'b0;
    end else if (w_push && (!r_vld_p0 || w_pop)) begin
      w_ld_p0_in   = 1'b1;
      w_vld_p0_nxt = 1'b1;
    end else if (w_push) begin
      w_ld_p1_in   = 1'b1;
      w_vld_p1_nxt = 1'b1;
    end else if (w_pop) begin
      w_vld_p0_nxt = 1'b0;
    end
  end

  // Control state and buffer head
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0   <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_in_ready <= 1'b1;
      r_z_p0     <= '0;
      r_f_p0     <= '0;
    end else begin
      r_vld_p0   <= w_vld_p0_nxt;
      r_vld_p1   <= w_vld_p1_nxt;
      r_in_ready <= !w_vld_p1_nxt;
      if (w_ld_p0_p1) begin
        r_z_p0 <= r_z_p1;
        r_f_p0 <= r_f_p1;
      end else if (w_ld_p0_in) begin
        r_z_p0 <= in_z;
        r_f_p0 <= in_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_p1_in) begin
      r_z_p1 <= in_z;
      r_f_p1 <= in_flags;
    end
  end

  // Retire side effects
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat       <= '0;
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end else begin
      if (w_pop) r_stat <= r_f_p0;
      if (clr_sticky) begin
        r_ovf_sticky <= 1'b0;
        r_ovf_count  <= '0;
      end else if (w_pop && r_f_p0[V_BIT]) begin
        r_ovf_sticky <= 1'b1;
        r_ovf_count  <= sat_inc(r_ovf_count);
      end
    end
  end

`ifdef PARITY_CHECK_EN
  logic r_par_err;
  logic w_par_bad;

  assign w_par_bad = (~^r_z_p0) != r_f_p0[P_BIT];

  always_ff @(posedge clk) begin
    if (rst)                    r_par_err <= 1'b0;
    else if (clr_sticky)        r_par_err <= 1'b0;
    else if (w_pop & w_par_bad) r_par_err <= 1'b1;
  end

  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'd0: cond_true = 1'b1;
      3'd1: cond_true = r_stat[Z_BIT];
      3'd2: cond_true = !r_stat[Z_BIT];
      3'd3: cond_true = r_stat[S_BIT];
      3'd4: cond_true = r_stat[C_BIT];
      3'd5: cond_true = r_stat[V_BIT];
      3'd6: cond_true = r_stat[P_BIT];
      default: cond_true = 1'b0;
    endcase
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_vld_p0;
  assign out_z      = r_z_p0;
  assign out_flags  = r_f_p0;
  assign stat       = r_stat;
  assign ovf_sticky = r_ovf_sticky;
  assign ovf_count  = r_ovf_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: handshake, ordering, status, overflow counter, parity flag.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_z;
  logic [4:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_z;
  logic [4:0]  out_flags;
  logic [4:0]  stat;
  logic [2:0]  cond;
  logic        cond_true;
  logic        ovf_sticky;
  logic [7:0]  ovf_count;
  logic        clr_sticky;
  logic        par_err;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] q[$];
  logic [15:0] nz;
  logic        exp_par;

  alu_result_stage #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_flags(out_flags),
    .stat(stat), .cond(cond), .cond_true(cond_true),
    .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .clr_sticky(clr_sticky),
    .par_err(par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] mkf(input logic [15:0] z, input logic v);
    return {1'b0, (z == 16'h0000), 1'b0, ~^z, v};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_z = '0; in_flags = '0;
    out_ready = 1'b0; cond = 3'd0; clr_sticky = 1'b0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_z", 32'(out_z), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_stat", 32'(stat), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    chk("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_par_err", 32'(par_err), 32'd0);
    rst = 1'b0;

    // single result, 8fff+8000
    in_valid = 1'b1; in_z = 16'h0FFF; in_flags = 5'b00111; out_ready = 1'b1;
    step();
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_out_z", 32'(out_z), 32'h0FFF);
    chk("t2_out_flags", 32'(out_flags), 32'h07);
    in_valid = 1'b0;
    step();
    chk("t2_out_valid_after", 32'(out_valid), 32'd0);
    chk("t2_stat", 32'(stat), 32'h07);
    chk("t2_sticky", 32'(ovf_sticky), 32'd1);
    chk("t2_count", 32'(ovf_count), 32'd1);
    cond = 3'd5; #1;
    chk("t2_cond_v", 32'(cond_true), 32'd1);

    // fill with consumer stalled, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_z = 16'h0000; in_flags = 5'b01110;
    step();
    chk("t3_in_ready_1", 32'(in_ready), 32'd1);
    chk("t3_out_z_1", 32'(out_z), 32'h0000);
    in_z = 16'hFFFF; in_flags = 5'b10010;
    step();
    chk("t3_in_ready_full", 32'(in_ready), 32'd0);
    chk("t3_out_valid", 32'(out_valid), 32'd1);
    chk("t3_out_z_2", 32'(out_z), 32'h0000);
    in_valid = 1'b0;
    step();
    chk("t3_hold_z", 32'(out_z), 32'h0000);
    chk("t3_hold_flags", 32'(out_flags), 32'h0E);
    out_ready = 1'b1;
    step();
    chk("t3_pop1_z", 32'(out_z), 32'hFFFF);
    chk("t3_pop1_stat", 32'(stat), 32'h0E);
    chk("t3_pop1_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("t3_pop2_valid", 32'(out_valid), 32'd0);
    chk("t3_pop2_stat", 32'(stat), 32'h12);
    cond = 3'd3; #1;
    chk("t3_cond_s", 32'(cond_true), 32'd1);
    cond = 3'd1; #1;
    chk("t3_cond_z", 32'(cond_true), 32'd0);
    chk("t3_count", 32'(ovf_count), 32'd1);

    // streaming at occupancy 1
    out_ready = 1'b0; in_valid = 1'b1; in_z = 16'h1000; in_flags = mkf(16'h1000, 1'b0);
    q.push_back(16'h1000);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nz = 16'h2000 + 16'(i * 3);
      chk("t4_head", 32'(out_z), 32'(q[0]));
      chk("t4_in_ready", 32'(in_ready), 32'd1);
      chk("t4_out_valid", 32'(out_valid), 32'd1);
      in_z = nz; in_flags = mkf(nz, 1'b0);
      step();
      void'(q.pop_front());
      q.push_back(nz);
    end
    in_valid = 1'b0;
    chk("t4_last", 32'(out_z), 32'(q[0]));
    step();
    void'(q.pop_front());
    chk("t4_drained", 32'(out_valid), 32'd0);
    chk("t4_count", 32'(ovf_count), 32'd1);

    // overflow counter saturation
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("t5_clr_count", 32'(ovf_count), 32'd0);
    chk("t5_clr_sticky", 32'(ovf_sticky), 32'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      in_z = 16'(k); in_flags = mkf(16'(k), 1'b1);
      step();
      if (k == 255) chk("t5_count_fe", 32'(ovf_count), 32'hFE);
    end
    in_valid = 1'b0;
    step();
    chk("t5_count_sat", 32'(ovf_count), 32'hFF);
    chk("t5_sticky", 32'(ovf_sticky), 32'd1);
    chk("t5_empty", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_z = 16'h8000; in_flags = mkf(16'h8000, 1'b1);
    step();
    in_valid = 1'b0; clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("t5_clrwin_count", 32'(ovf_count), 32'd0);
    chk("t5_clrwin_sticky", 32'(ovf_sticky), 32'd0);
    chk("t5_clrwin_stat", 32'(stat), 32'h01);

    // parity recheck: 0x0001 has odd weight but is tagged P=1
    in_valid = 1'b1; in_z = 16'h0001; in_flags = 5'b00010;
    step();
    in_valid = 1'b0;
    step();
`ifdef PARITY_CHECK_EN
    exp_par = 1'b1;
`else
    exp_par = 1'b0;
`endif
    chk("t6_par_err", 32'(par_err), 32'(exp_par));
    chk("t6_stat", 32'(stat), 32'h02);
    cond = 3'd6; #1;
    chk("t6_cond_p", 32'(cond_true), 32'd1);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("t6_par_clr", 32'(par_err), 32'd0);

    // reset with two buffered entries
    out_ready = 1'b0; in_valid = 1'b1; in_z = 16'hAAAA; in_flags = mkf(16'hAAAA, 1'b1);
    step();
    in_z = 16'h5555; in_flags = mkf(16'h5555, 1'b1);
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t7_out_valid", 32'(out_valid), 32'd0);
    chk("t7_in_ready", 32'(in_ready), 32'd1);
    chk("t7_stat", 32'(stat), 32'd0);
    chk("t7_out_z", 32'(out_z), 32'd0);
    in_valid = 1'b1; in_z = 16'h1234; in_flags = mkf(16'h1234, 1'b0);
    step();
    in_valid = 1'b0;
    chk("t7_new_head", 32'(out_z), 32'h1234);
    chk("t7_in_ready_after", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
